// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter in front of a single-ported
//               data RAM. Port 0 is the CPU load/store path, port 1 is the
//               DMA/loader path. Registered grant/command outputs, range
//               checking, and a read-return tracker that routes RAM data
//               back to the issuing port one cycle after its grant.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              stall0,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    // Grant / command registers
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_err0;
    logic              r_err1;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wd;
    // Last-served pointer: 1 means port 1 was served last, so port 0 wins a tie
    logic              r_last;
    // Read tracker, loaded with each read grant
    logic              r_trk_vld;
    logic              r_trk_owner;
    logic              r_trk_oor;
    // Read return stage, aligned with mem_rd
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              r_rd_oor;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_oor0;
    logic              w_oor1;
    logic              w_pick0;
    logic              w_pick1;
    logic              w_grant;
    logic              w_sel_we;
    logic              w_sel_oor;
    logic [31:0]       w_sel_addr;
    logic [DATA_W-1:0] w_sel_wd;
    logic              w_unused;

    // A port granted this cycle is still holding its old request; skip it.
    assign w_elig0 = req0 & ~r_gnt0;
    assign w_elig1 = req1 & ~r_gnt1;

    // Anything above the RAM's word range is out of range.
    assign w_oor0 = |addr0[31:ADDR_W+2];
    assign w_oor1 = |addr1[31:ADDR_W+2];

    // Byte-offset bits are intentionally ignored.
    assign w_unused = ^{addr0[1:0], addr1[1:0]};

    // Pick a winner: round-robin on a tie, otherwise the lone eligible port
    always_comb begin
        w_pick0 = 1'b0;
        w_pick1 = 1'b0;
        if (w_elig0 && w_elig1) begin
            w_pick0 = r_last;
            w_pick1 = ~r_last;
        end else begin
            w_pick0 = w_elig0;
            w_pick1 = w_elig1;
        end
    end

    assign w_grant    = w_pick0 | w_pick1;
    assign w_sel_we   = w_pick1 ? we1    : we0;
    assign w_sel_oor  = w_pick1 ? w_oor1 : w_oor0;
    assign w_sel_addr = w_pick1 ? addr1  : addr0;
    assign w_sel_wd   = w_pick1 ? wd1    : wd0;

    // Register the winner's grant, error flag and RAM command
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
        end else begin
            r_gnt0     <= w_pick0;
            r_gnt1     <= w_pick1;
            r_err0     <= w_pick0 & w_oor0;
            r_err1     <= w_pick1 & w_oor1;
            r_mem_en   <= w_grant;
            r_mem_we   <= w_grant & w_sel_we & ~w_sel_oor;
            r_mem_addr <= w_grant ? w_sel_addr[ADDR_W+1:2] : '0;
            r_mem_wd   <= w_grant ? w_sel_wd : '0;
        end
    end

    // Advance the last-served pointer only when something is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_pick1;
        end
    end

    // Record owner and range status of each read as it is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trk_vld   <= 1'b0;
            r_trk_owner <= 1'b0;
            r_trk_oor   <= 1'b0;
        end else begin
            r_trk_vld   <= w_grant & ~w_sel_we;
            r_trk_owner <= w_pick1;
            r_trk_oor   <= w_sel_oor;
        end
    end

    // Move the tracker into the return stage, aligned with mem_rd
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rd_oor  <= 1'b0;
        end else begin
            r_rvalid0 <= r_trk_vld & ~r_trk_owner;
            r_rvalid1 <= r_trk_vld & r_trk_owner;
            r_rd_oor  <= r_trk_oor;
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign err0     = r_err0;
    assign err1     = r_err1;
    assign mem_en   = r_mem_en;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_wd   = r_mem_wd;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    // Out-of-range reads return zero instead of whatever the RAM aliased to.
    assign rdata0   = (r_rvalid0 && !r_rd_oor) ? mem_rd : '0;
    assign rdata1   = (r_rvalid1 && !r_rd_oor) ? mem_rd : '0;
    assign stall0   = req0 & ~r_gnt0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a small
//               behavioural RAM attached to the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              req0, req1, we0, we1;
    logic [31:0]       addr0, addr1;
    logic [DATA_W-1:0] wd0, wd1;
    logic              gnt0, gnt1, rvalid0, rvalid1, err0, err1, stall0;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    int checks;
    int errors;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .stall0(stall0), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency; known words loaded in reset
    always @(posedge clk) begin
        if (rst) begin
            ram[0] <= 32'hFFFF_FFFF;
            ram[2] <= 32'h2222_2222;
            ram[4] <= 32'hDEAD_BEEF;
            mem_rd <= '0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wd;
            mem_rd <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b1;
        // Request held through reset must be ignored until rst drops
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        tick();
        tick();
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_err0", {31'd0, err0}, 32'd0);

        // Single read of 0x10
        rst = 1'b0;
        tick();
        chk("rd_gnt0", {31'd0, gnt0}, 32'd1);
        chk("rd_mem_en", {31'd0, mem_en}, 32'd1);
        chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rd_mem_addr", {20'd0, mem_addr}, 32'd4);
        chk("rd_err0", {31'd0, err0}, 32'd0);
        chk("rd_stall0", {31'd0, stall0}, 32'd0);
        idle();
        tick();
        chk("rd_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("rd_rdata0", rdata0, 32'hDEAD_BEEF);
        chk("rd_gnt0_gone", {31'd0, gnt0}, 32'd0);
        tick();
        chk("rd_rvalid0_once", {31'd0, rvalid0}, 32'd0);

        // Contention right after reset: port 0 first, then alternating
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1'b1; addr0 = 32'h0;
        req1 = 1'b1; addr1 = 32'h8;
        #1;
        chk("cont_stall0_pre", {31'd0, stall0}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("cont_gnt0_%0d", i), {31'd0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("cont_gnt1_%0d", i), {31'd0, gnt1}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("cont_stall0_%0d", i), {31'd0, stall0}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        idle();
        tick();
        tick();
        tick();

        // Out-of-range write from port 1 (aliases to word 0)
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4000; wd1 = 32'h1234_5678;
        tick();
        chk("oorw_gnt1", {31'd0, gnt1}, 32'd1);
        chk("oorw_err1", {31'd0, err1}, 32'd1);
        chk("oorw_mem_en", {31'd0, mem_en}, 32'd1);
        chk("oorw_mem_we", {31'd0, mem_we}, 32'd0);
        idle();
        tick();
        chk("oorw_no_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("oorw_err1_gone", {31'd0, err1}, 32'd0);

        // In-range write from port 1 to word 8
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wd1 = 32'hCAFE_0001;
        tick();
        chk("wr_gnt1", {31'd0, gnt1}, 32'd1);
        chk("wr_err1", {31'd0, err1}, 32'd0);
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_addr", {20'd0, mem_addr}, 32'd8);
        chk("wr_mem_wd", mem_wd, 32'hCAFE_0001);
        idle();
        tick();
        chk("wr_no_rvalid1", {31'd0, rvalid1}, 32'd0);

        // Out-of-range read from port 0: RAM word 0 holds all ones
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0001_0000;
        tick();
        chk("oorr_gnt0", {31'd0, gnt0}, 32'd1);
        chk("oorr_err0", {31'd0, err0}, 32'd1);
        idle();
        tick();
        chk("oorr_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("oorr_rdata0", rdata0, 32'd0);

        // Read back the in-range write; word 0 untouched by the rejected write
        req0 = 1'b1; addr0 = 32'h20;
        tick();
        chk("rb_gnt0", {31'd0, gnt0}, 32'd1);
        idle();
        tick();
        chk("rb_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("rb_rdata0", rdata0, 32'hCAFE_0001);
        chk("oorw_ram0_kept", ram[0], 32'hFFFF_FFFF);

        // Pipelined reads on consecutive cycles
        req0 = 1'b1; addr0 = 32'h0;
        tick();
        chk("pipe_gnt0", {31'd0, gnt0}, 32'd1);
        idle();
        req1 = 1'b1; addr1 = 32'h8;
        tick();
        chk("pipe_gnt1", {31'd0, gnt1}, 32'd1);
        chk("pipe_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("pipe_rdata0", rdata0, 32'hFFFF_FFFF);
        chk("pipe_rvalid1_early", {31'd0, rvalid1}, 32'd0);
        idle();
        tick();
        chk("pipe_rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("pipe_rdata1", rdata1, 32'h2222_2222);
        chk("pipe_rvalid0_done", {31'd0, rvalid0}, 32'd0);

        // Reset in the cycle a read is granted; pointer currently favours port 1
        req0 = 1'b1; addr0 = 32'h10;
        tick();
        chk("rstrd_gnt0", {31'd0, gnt0}, 32'd1);
        idle();
        rst = 1'b1;
        req1 = 1'b1; addr1 = 32'h8;
        tick();
        chk("rstrd_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rstrd_gnt0_clr", {31'd0, gnt0}, 32'd0);
        chk("rstrd_gnt1_ignored", {31'd0, gnt1}, 32'd0);
        chk("rstrd_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rstrd_mem_wd", mem_wd, 32'd0);
        rst = 1'b0;
        req0 = 1'b1; addr0 = 32'h10;
        tick();
        chk("rstrd_tie_gnt0", {31'd0, gnt0}, 32'd1);
        chk("rstrd_tie_gnt1", {31'd0, gnt1}, 32'd0);
        chk("rstrd_late_rvalid0", {31'd0, rvalid0}, 32'd0);
        idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the shared data RAM (4K words).
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0/req1  input  1 each  access request; port 0 is the CPU load/store path, port 1 is the DMA/loader path.
REQ-006 we0/we1  input  1 each  1 = write, 0 = read.
REQ-007 addr0/addr1  input  32 each  byte address; bits [1:0] are ignored.
REQ-008 wd0/wd1  input  DATA_W each  write data.
REQ-009 gnt0/gnt1  output  1 each  one-cycle acceptance pulse.
REQ-010 rvalid0/rvalid1  output  1 each  one-cycle read-data-valid pulse.
REQ-011 rdata0/rdata1  output  DATA_W each  read data; meaningful only while the matching rvalid is high.
REQ-012 err0/err1  output  1 each  out-of-range flag, pulsed together with that access's gnt.
REQ-013 stall0  output  1  req0 & ~gnt0, for freezing the CPU PC.
REQ-014 mem_en, mem_we  output  1 each  RAM command strobe and write enable.
REQ-015 mem_addr  output  ADDR_W  RAM word address.
REQ-016 mem_wd  output  DATA_W  RAM write data.
REQ-017 mem_rd  input  DATA_W  RAM read data, valid one cycle after a read command.

Function
REQ-018 Requester SHALL hold req, we, addr and wd stable from assertion until the cycle gnt is high.
- Requester SHALL deassert req, or present a new request, in the following cycle.
REQ-019 Arbitration SHALL sample the requests at cycle T; the winner's gnt, mem_en and command fields SHALL all be registered outputs at T+1.
REQ-020 A port whose gnt is high in cycle T SHALL be ineligible for arbitration in cycle T; one access SHALL be issued per cycle at most.
REQ-021 Ties SHALL be broken round-robin using a last-served pointer.
- Pointer reset value 1, so port 0 wins the first tie.
- The pointer SHALL update only on a grant.
REQ-022 Single eligible requester SHALL win regardless of the pointer.
REQ-023 mem_addr SHALL equal addr_i[ADDR_W+1:2]; mem_wd = wd_i; mem_we = we_i & ~err.
REQ-024 An access is out of range when addr_i[31:ADDR_W+2] != 0.
- err_i SHALL pulse with gnt_i.
- The access SHALL still consume the slot, with mem_we forced to 0.
REQ-025 For a granted read, rvalid_i SHALL pulse at T+2, one cycle after gnt.
- rdata_i SHALL equal mem_rd, or 0 if that access was out of range.
- Writes SHALL produce no rvalid.
REQ-026 A 2-bit read tracker (owner, oor) SHALL be registered with each read grant.
- Back-to-back reads from alternating ports SHALL return data in issue order without loss.
REQ-027 When mem_en = 0, mem_we SHALL be 0; mem_addr and mem_wd are don't-care.

Reset
REQ-028 Synchronous rst SHALL force to 0: gnt*, rvalid*, err*, mem_en, mem_we, mem_addr, mem_wd and the tracker.
- The pointer SHALL be set to 1.
REQ-029 A read granted in the cycle before rst SHALL produce no rvalid after reset.
- Requests present during rst SHALL be ignored; arbitration resumes in the first cycle with rst low.

Verification
REQ-030 Single read: req0=1, we0=0, addr0=0x10 at T -> at T+1 gnt0=1, mem_en=1, mem_addr=4; mem_rd=0xDEADBEEF at T+2 -> rvalid0=1, rdata0=0xDEADBEEF.
REQ-031 Contention: req0 and req1 held continuously after reset -> grants alternate gnt0, gnt1, gnt0, ...; never two grants in one cycle; stall0=1 on every cycle without gnt0.
REQ-032 Out-of-range write: req1=1, we1=1, addr1=0x4000 -> gnt1=1 and err1=1 at T+1, mem_we=0; RAM contents unchanged.
REQ-033 Out-of-range read: addr0=0x00010000 -> err0 with gnt0; rvalid0 at T+2 with rdata0=0 even if mem_rd=0xFFFFFFFF.
REQ-034 Reset mid-read: gnt0 for a read at T+1, rst=1 at T+1 -> rvalid0=0 at T+2; all outputs 0; the next tie goes to port 0.
REQ-035 Pipelined reads: port 0 read at 0x0 and port 1 read at 0x8, granted on consecutive cycles -> rvalid0 then rvalid1 on consecutive cycles, each with its own mem_rd word.
